// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined ROR/ROL/LSR/ASR barrel shifter, one stage per amount bit, valid/ready on both sides
// Define BSHIFT_CARRY_EN to add the registered O_CARRY output.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I,
  input  logic [SW-1:0]    S,
  input  logic [1:0]       MODE,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] O,
  output logic             O_VALID,
  input  logic             O_READY
`ifdef BSHIFT_CARRY_EN
  ,
  output logic             O_CARRY
`endif
);

  localparam logic [1:0] MODE_ROR = 2'b00;
  localparam logic [1:0] MODE_ROL = 2'b01;
  localparam logic [1:0] MODE_LSR = 2'b10;

  logic [SW-1:0]            valid_q, valid_d;
  logic [SW-1:0][WIDTH-1:0] data_q, data_d;
  logic [SW-1:0][SW-1:0]    amt_q, amt_d;
  logic [SW-1:0][1:0]       mode_q, mode_d;
  logic [SW:0]              ready;

  logic [SW-1:0]            up_valid;
  logic [SW-1:0][WIDTH-1:0] up_data;
  logic [SW-1:0][SW-1:0]    up_amt;
  logic [SW-1:0][1:0]       up_mode;

`ifdef BSHIFT_CARRY_EN
  logic [SW-1:0] carry_q, carry_d, up_carry;
`endif

  // ASR uses the current word's MSB; every earlier ASR stage preserved the original MSB.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] m, input int sh);
    case (m)
      MODE_ROR: shift_step = (d >> sh) | (d << (WIDTH - sh));
      MODE_ROL: shift_step = (d << sh) | (d >> (WIDTH - sh));
      MODE_LSR: shift_step = d >> sh;
      default:  shift_step = $signed(d) >>> sh;
    endcase
  endfunction

`ifdef BSHIFT_CARRY_EN
  // Bit that lands in O[WIDTH-1] (ROR) or leaves last (LSR/ASR) is d[sh-1]; for ROL it is d[WIDTH-sh] -> O[0].
  function automatic logic carry_step(input logic [WIDTH-1:0] d,
                                      input logic [1:0] m, input int sh);
    logic [WIDTH-1:0] t;
    if (m == MODE_ROL) t = d >> (WIDTH - sh);
    else               t = d >> (sh - 1);
    return t[0];
  endfunction
`endif

  always_comb begin
    ready     = '0;
    ready[SW] = O_READY;
    for (int k = SW - 1; k >= 0; k--) begin
      ready[k] = !valid_q[k] || ready[k+1];
    end
  end

  assign I_READY = ready[0];

  always_comb begin
    up_valid    = '0;
    up_data     = '0;
    up_amt      = '0;
    up_mode     = '0;
    up_valid[0] = I_VALID;
    up_data[0]  = I;
    up_amt[0]   = S;
    up_mode[0]  = MODE;
    for (int k = 1; k < SW; k++) begin
      up_valid[k] = valid_q[k-1];
      up_data[k]  = data_q[k-1];
      up_amt[k]   = amt_q[k-1];
      up_mode[k]  = mode_q[k-1];
    end
  end

`ifdef BSHIFT_CARRY_EN
  always_comb begin
    up_carry = '0;
    for (int k = 1; k < SW; k++) begin
      up_carry[k] = carry_q[k-1];
    end
  end
`endif

  // Payload only moves with a valid beat, so a stalled or drained stage keeps its last word.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    mode_d  = mode_q;
`ifdef BSHIFT_CARRY_EN
    carry_d = carry_q;
`endif
    for (int k = 0; k < SW; k++) begin
      if (ready[k]) begin
        valid_d[k] = up_valid[k];
        if (up_valid[k]) begin
          amt_d[k]  = up_amt[k];
          mode_d[k] = up_mode[k];
          if (up_amt[k][k]) begin
            data_d[k]  = shift_step(up_data[k], up_mode[k], 1 << k);
`ifdef BSHIFT_CARRY_EN
            carry_d[k] = carry_step(up_data[k], up_mode[k], 1 << k);
`endif
          end else begin
            data_d[k]  = up_data[k];
`ifdef BSHIFT_CARRY_EN
            carry_d[k] = up_carry[k];
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
`ifdef BSHIFT_CARRY_EN
      carry_q <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
`ifdef BSHIFT_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end

  assign O       = data_q[SW-1];
  assign O_VALID = valid_q[SW-1];
`ifdef BSHIFT_CARRY_EN
  assign O_CARRY = carry_q[SW-1];
`endif

  // The last stage's amount and mode have no consumer downstream.
  logic unused_tail;
  assign unused_tail = ^{amt_q[SW-1], mode_q[SW-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - scoreboard bench for pipelined_barrel_shifter (WIDTH=8 and WIDTH=4)
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] i8, o8;
  logic [2:0] s8;
  logic [1:0] m8;
  logic       iv8, ir8, ov8, or8;
  logic [3:0] i4, o4;
  logic [1:0] s4, m4;
  logic       iv4, ir4, ov4, or4;
`ifdef BSHIFT_CARRY_EN
  logic       oc8, oc4;
`endif

  pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
    .CLK(clk), .RESET(rst), .I(i8), .S(s8), .MODE(m8),
    .I_VALID(iv8), .I_READY(ir8), .O(o8), .O_VALID(ov8), .O_READY(or8)
`ifdef BSHIFT_CARRY_EN
    , .O_CARRY(oc8)
`endif
  );

  pipelined_barrel_shifter #(.WIDTH(4)) dut4 (
    .CLK(clk), .RESET(rst), .I(i4), .S(s4), .MODE(m4),
    .I_VALID(iv4), .I_READY(ir4), .O(o4), .O_VALID(ov4), .O_READY(or4)
`ifdef BSHIFT_CARRY_EN
    , .O_CARRY(oc4)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic       c;
    int         acc;
  } exp_t;

  exp_t sb8[$];
  exp_t sb4[$];
  exp_t e8, e4;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int prev_cyc = -1;
  bit gap_chk = 1'b0;
  int lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst && ov8 && or8) begin
      if (sb8.size() == 0) begin
        check("dut8_spurious_beat", 32'(o8), 32'hFFFF_FFFF);
      end else begin
        e8 = sb8.pop_front();
        check("dut8_data", 32'(o8), 32'(e8.d));
`ifdef BSHIFT_CARRY_EN
        check("dut8_carry", 32'(oc8), 32'(e8.c));
`endif
        if (gap_chk) begin
          if (prev_cyc >= 0) check("dut8_no_gap", cyc - prev_cyc, 1);
          prev_cyc = cyc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov4 && or4) begin
      if (sb4.size() == 0) begin
        check("dut4_spurious_beat", 32'(o4), 32'hFFFF_FFFF);
      end else begin
        e4 = sb4.pop_front();
        check("dut4_data", 32'(o4), 32'(e4.d));
        check("dut4_latency", cyc - e4.acc, 2);
`ifdef BSHIFT_CARRY_EN
        check("dut4_carry", 32'(oc4), 32'(e4.c));
`endif
      end
    end
  end

  task automatic send8(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                       input logic [7:0] ed, input logic ec);
    bit ok = 1'b0;
    i8 = d; s8 = s; m8 = m; iv8 = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (ir8) begin
        sb8.push_back('{ed, ec, cyc});
        ok = 1'b1;
      end
    end
    if (!ok) check("dut8_accept_timeout", 0, 1);
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic send4(input logic [3:0] d, input logic [1:0] s, input logic [3:0] ed, input logic ec);
    bit ok = 1'b0;
    i4 = d; s4 = s; m4 = 2'b00; iv4 = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (ir4) begin
        sb4.push_back('{{4'b0, ed}, ec, cyc});
        ok = 1'b1;
      end
    end
    if (!ok) check("dut4_accept_timeout", 0, 1);
    @(posedge clk); #1;
    iv4 = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 200 && (sb8.size() + sb4.size()) != 0; n++) @(negedge clk);
    check(name, sb8.size() + sb4.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic measure_latency8(output int l);
    l = 0;
    for (int n = 1; n <= 20 && l == 0; n++) begin
      @(negedge clk);
      if (ov8) l = n;
    end
  endtask

  initial begin
    rst = 1'b1;
    i8 = '0; s8 = '0; m8 = '0; iv8 = 1'b0; or8 = 1'b0;
    i4 = '0; s4 = '0; m4 = '0; iv4 = 1'b0; or4 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_i_ready", 32'(ir8), 1);
    check("reset_o_valid", 32'(ov8), 0);
    check("reset_o", 32'(o8), 0);
    check("reset_dut4_o_valid", 32'(ov4), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    or8 = 1'b1;

    // single beat and its latency
    send8(8'h81, 3'd1, 2'b00, 8'hC0, 1'b1);
    measure_latency8(lat);
    check("dut8_latency", lat, 3);
    wait_drain("drain_single");

    // back-to-back stream, one result per cycle
    gap_chk = 1'b1; prev_cyc = -1;
    send8(8'h81, 3'd3, 2'b01, 8'h0C, 1'b0);
    send8(8'hB4, 3'd3, 2'b10, 8'h16, 1'b1);
    send8(8'h80, 3'd3, 2'b11, 8'hF0, 1'b0);
    send8(8'h5A, 3'd0, 2'b00, 8'h5A, 1'b0);
    wait_drain("drain_stream");
    gap_chk = 1'b0;

    // backpressure: three beats fill the pipe, output holds, release drains all five
    or8 = 1'b0;
    send8(8'h01, 3'd1, 2'b00, 8'h80, 1'b1);
    send8(8'hFF, 3'd4, 2'b10, 8'h0F, 1'b1);
    send8(8'h7F, 3'd2, 2'b11, 8'h1F, 1'b1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("bp_i_ready_low", 32'(ir8), 0);
      check("bp_o_valid_hold", 32'(ov8), 1);
      check("bp_o_hold", 32'(o8), 32'h80);
    end
    @(posedge clk); #1;
    gap_chk = 1'b1; prev_cyc = -1;
    fork
      begin
        send8(8'h0F, 3'd4, 2'b01, 8'hF0, 1'b0);
        send8(8'h03, 3'd1, 2'b10, 8'h01, 1'b1);
      end
      begin
        repeat (2) @(posedge clk);
        #1 or8 = 1'b1;
      end
    join
    wait_drain("drain_backpressure");
    gap_chk = 1'b0;

    // boundary amounts and S=0 in several modes
    send8(8'h80, 3'd7, 2'b10, 8'h01, 1'b0);
    send8(8'h80, 3'd7, 2'b11, 8'hFF, 1'b0);
    send8(8'h01, 3'd7, 2'b01, 8'h80, 1'b0);
    send8(8'h40, 3'd7, 2'b11, 8'h00, 1'b1);
    send8(8'h81, 3'd7, 2'b00, 8'h03, 1'b0);
    send8(8'hA5, 3'd0, 2'b10, 8'hA5, 1'b0);
    send8(8'hA5, 3'd0, 2'b01, 8'hA5, 1'b0);
    wait_drain("drain_boundary");

    // reset with three beats in flight
    or8 = 1'b0;
    send8(8'h11, 3'd1, 2'b00, 8'h88, 1'b1);
    send8(8'h22, 3'd1, 2'b00, 8'h11, 1'b0);
    send8(8'h33, 3'd1, 2'b00, 8'h99, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb8.delete();
    @(negedge clk);
    check("midrst_o_valid", 32'(ov8), 0);
    check("midrst_o", 32'(o8), 0);
    check("midrst_i_ready", 32'(ir8), 1);
    or8 = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(ov8), 0);
    end
    @(posedge clk); #1;
    send8(8'h81, 3'd1, 2'b00, 8'hC0, 1'b1);
    measure_latency8(lat);
    check("post_reset_latency", lat, 3);
    wait_drain("drain_post_reset");

    // WIDTH=4 exhaustive rotate-right
    for (int a = 0; a < 16; a++) begin
      for (int s = 0; s < 4; s++) begin
        logic [3:0] av, ev;
        av = 4'(a);
        ev = 4'(((a >> s) | (a << (4 - s))) & 15);
        send4(av, 2'(s), ev, (s == 0) ? 1'b0 : ev[3]);
      end
    end
    wait_drain("drain_dut4");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
